// File: rtl/copperv_pkg.sv
// Shared widths and writeback source encoding
// for the register-file access scheduler.
package copperv_pkg;

  localparam int REG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;

  typedef enum logic {
    WB_EX = 1'b0,
    WB_LD = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, x0 never pending.
// Ports: set/clear strobes with index, three busy lookups.
module rf_scoreboard #(
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en_i,
  input  logic [RW-1:0] set_idx_i,
  input  logic          clr_en_i,
  input  logic [RW-1:0] clr_idx_i,
  input  logic [RW-1:0] lk1_idx_i,
  input  logic [RW-1:0] lk2_idx_i,
  input  logic [RW-1:0] lk3_idx_i,
  output logic          lk1_busy_o,
  output logic          lk2_busy_o,
  output logic          lk3_busy_o
);

  localparam int N = 2 ** RW;

  logic [N-1:0] pend_q;
  logic [N-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_idx_i] = 1'b0;
    if (set_en_i) pend_d[set_idx_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_q <= '0;
    else      pend_q <= pend_d;
  end

  assign lk1_busy_o = pend_q[lk1_idx_i];
  assign lk2_busy_o = pend_q[lk2_idx_i];
  assign lk3_busy_o = pend_q[lk3_idx_i];

endmodule

// File: rtl/regfile_scheduler.sv
// Arbitrates exec/load writeback and operand reads onto one regfile slot,
// with reservation scoreboard and read anti-starvation counter.
module regfile_scheduler
  import copperv_pkg::*;
#(
  parameter int REG_WIDTH    = copperv_pkg::REG_WIDTH,
  parameter int DATA_WIDTH   = copperv_pkg::DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rsv_valid,
  input  logic [REG_WIDTH-1:0]  rsv_rd,
  output logic                  rsv_ready,
  input  logic                  rd_req_valid,
  input  logic [REG_WIDTH-1:0]  rd_req_rs1,
  input  logic [REG_WIDTH-1:0]  rd_req_rs2,
  output logic                  rd_req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rs1,
  output logic [DATA_WIDTH-1:0] rsp_rs2,
  input  logic                  wb_ex_valid,
  input  logic [REG_WIDTH-1:0]  wb_ex_rd,
  input  logic [DATA_WIDTH-1:0] wb_ex_data,
  output logic                  wb_ex_ready,
  input  logic                  wb_ld_valid,
  input  logic [REG_WIDTH-1:0]  wb_ld_rd,
  input  logic [DATA_WIDTH-1:0] wb_ld_data,
  output logic                  wb_ld_ready,
  output logic                  rf_rd_en,
  output logic [REG_WIDTH-1:0]  rf_rd,
  output logic [DATA_WIDTH-1:0] rf_rd_din,
  output logic                  rf_rs1_en,
  output logic                  rf_rs2_en,
  output logic [REG_WIDTH-1:0]  rf_rs1,
  output logic [REG_WIDTH-1:0]  rf_rs2,
  input  logic [DATA_WIDTH-1:0] rf_rs1_dout,
  input  logic [DATA_WIDTH-1:0] rf_rs2_dout
);

  logic [3:0]           starve_q, starve_d;
  wb_src_e              rr_last_q, rr_last_d;
  logic                 rsp_valid_q;

  logic                 busy1, busy2, busy_rsv;
  logic                 rd_elig, starved, read_win;
  logic                 wr_any, wr_slot, sel_ld;
  logic [REG_WIDTH-1:0] wr_rd;
  logic                 set_en, clr_en;

  rf_scoreboard #(.RW(REG_WIDTH)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (set_en),
    .set_idx_i  (rsv_rd),
    .clr_en_i   (clr_en),
    .clr_idx_i  (wr_rd),
    .lk1_idx_i  (rd_req_rs1),
    .lk2_idx_i  (rd_req_rs2),
    .lk3_idx_i  (rsv_rd),
    .lk1_busy_o (busy1),
    .lk2_busy_o (busy2),
    .lk3_busy_o (busy_rsv)
  );

  always_comb begin
    rd_elig  = rd_req_valid & !busy1 & !busy2;
    starved  = (starve_q == 4'(STARVE_LIMIT));
    wr_any   = wb_ex_valid | wb_ld_valid;
    read_win = rd_elig & (!wr_any | starved);
    wr_slot  = wr_any & !read_win;
    // Round-robin only matters on a tie; the loser of last grant wins.
    if (wb_ex_valid & wb_ld_valid) sel_ld = (rr_last_q == WB_EX);
    else                           sel_ld = wb_ld_valid;
    wr_rd = sel_ld ? wb_ld_rd : wb_ex_rd;

    wb_ex_ready  = wr_slot & !sel_ld;
    wb_ld_ready  = wr_slot & sel_ld;
    rd_req_ready = read_win;
    rsv_ready    = (rsv_rd == '0) | !busy_rsv;

    rf_rd_en  = wr_slot & (wr_rd != '0);
    rf_rd     = wr_rd;
    rf_rd_din = sel_ld ? wb_ld_data : wb_ex_data;
    rf_rs1_en = read_win;
    rf_rs2_en = read_win;
    rf_rs1    = rd_req_rs1;
    rf_rs2    = rd_req_rs2;

    set_en = rsv_valid & rsv_ready & (rsv_rd != '0);
    clr_en = rf_rd_en;

    rr_last_d = rr_last_q;
    if (wr_slot) rr_last_d = sel_ld ? WB_LD : WB_EX;

    starve_d = starve_q;
    if (!rd_req_valid || read_win) starve_d = '0;
    else if (rd_elig && !starved)  starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q    <= '0;
      rr_last_q   <= WB_LD;
      rsp_valid_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      rr_last_q   <= rr_last_d;
      rsp_valid_q <= read_win;
    end
  end

  // Regfile registers its read data, so the response is a pass-through.
  assign rsp_valid = rsp_valid_q;
  assign rsp_rs1   = rf_rs1_dout;
  assign rsp_rs2   = rf_rs2_dout;

endmodule

// File: tb/tb_regfile_scheduler.sv
// Directed bench for regfile_scheduler with a behavioural register file.
// Inputs driven 1ns after posedge, outputs checked 2ns after posedge.
module tb_regfile_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rsv_valid = 1'b0;
  logic [4:0]  rsv_rd = '0;
  logic        rsv_ready;
  logic        rd_req_valid = 1'b0;
  logic [4:0]  rd_req_rs1 = '0;
  logic [4:0]  rd_req_rs2 = '0;
  logic        rd_req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rs1, rsp_rs2;
  logic        wb_ex_valid = 1'b0;
  logic [4:0]  wb_ex_rd = '0;
  logic [31:0] wb_ex_data = '0;
  logic        wb_ex_ready;
  logic        wb_ld_valid = 1'b0;
  logic [4:0]  wb_ld_rd = '0;
  logic [31:0] wb_ld_data = '0;
  logic        wb_ld_ready;
  logic        rf_rd_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_rd_din;
  logic        rf_rs1_en, rf_rs2_en;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rs1_dout = '0;
  logic [31:0] rf_rs2_dout = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  regfile_scheduler #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rsv_valid    (rsv_valid),
    .rsv_rd       (rsv_rd),
    .rsv_ready    (rsv_ready),
    .rd_req_valid (rd_req_valid),
    .rd_req_rs1   (rd_req_rs1),
    .rd_req_rs2   (rd_req_rs2),
    .rd_req_ready (rd_req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rs1      (rsp_rs1),
    .rsp_rs2      (rsp_rs2),
    .wb_ex_valid  (wb_ex_valid),
    .wb_ex_rd     (wb_ex_rd),
    .wb_ex_data   (wb_ex_data),
    .wb_ex_ready  (wb_ex_ready),
    .wb_ld_valid  (wb_ld_valid),
    .wb_ld_rd     (wb_ld_rd),
    .wb_ld_data   (wb_ld_data),
    .wb_ld_ready  (wb_ld_ready),
    .rf_rd_en     (rf_rd_en),
    .rf_rd        (rf_rd),
    .rf_rd_din    (rf_rd_din),
    .rf_rs1_en    (rf_rs1_en),
    .rf_rs2_en    (rf_rs2_en),
    .rf_rs1       (rf_rs1),
    .rf_rs2       (rf_rs2),
    .rf_rs1_dout  (rf_rs1_dout),
    .rf_rs2_dout  (rf_rs2_dout)
  );

  // Behavioural register file: registered read, x0 reads zero.
  always @(posedge clk) begin
    if (rf_rd_en && rf_rd != 5'd0) mem[rf_rd] <= rf_rd_din;
    if (rf_rs1_en) rf_rs1_dout <= (rf_rs1 == 5'd0) ? 32'd0 : mem[rf_rs1];
    if (rf_rs2_en) rf_rs2_dout <= (rf_rs2 == 5'd0) ? 32'd0 : mem[rf_rs2];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;

    // Reset state
    tick();
    tick();
    rsv_rd = 5'd5;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsv_ready", 32'(rsv_ready), 32'd1);
    check("rst_rd_ready", 32'(rd_req_ready), 32'd0);
    check("rst_rf_rs_en", 32'(rf_rs1_en), 32'd0);
    check("rst_rf_rd_en", 32'(rf_rd_en), 32'd0);
    rst = 1'b1;
    rsv_rd = 5'd0;
    tick();

    // Round-robin: ex,ld,ex,ld with both valid
    wb_ex_valid = 1'b1; wb_ex_rd = 5'd3; wb_ex_data = 32'h11;
    wb_ld_valid = 1'b1; wb_ld_rd = 5'd4; wb_ld_data = 32'h22;
    #1;
    check("rr1_ex", 32'(wb_ex_ready), 32'd1);
    check("rr1_ld", 32'(wb_ld_ready), 32'd0);
    check("rr1_rf_rd_en", 32'(rf_rd_en), 32'd1);
    tick();
    wb_ex_data = 32'h33;
    #1;
    check("rr2_ex", 32'(wb_ex_ready), 32'd0);
    check("rr2_ld", 32'(wb_ld_ready), 32'd1);
    tick();
    wb_ld_data = 32'h44;
    #1;
    check("rr3_ex", 32'(wb_ex_ready), 32'd1);
    check("rr3_ld", 32'(wb_ld_ready), 32'd0);
    tick();
    wb_ex_data = 32'h55;
    #1;
    check("rr4_ex", 32'(wb_ex_ready), 32'd0);
    check("rr4_ld", 32'(wb_ld_ready), 32'd1);
    tick();
    wb_ex_valid = 1'b0; wb_ld_valid = 1'b0;
    rd_req_valid = 1'b1; rd_req_rs1 = 5'd3; rd_req_rs2 = 5'd4;
    #1;
    check("rr_rd_ready", 32'(rd_req_ready), 32'd1);
    check("rr_rs_en2", 32'(rf_rs2_en), 32'd1);
    tick();
    rd_req_valid = 1'b0;
    #1;
    check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rr_rsp_rs1", rsp_rs1, 32'h33);
    check("rr_rsp_rs2", rsp_rs2, 32'h44);
    tick();
    #1;
    check("rsp_pulse", 32'(rsp_valid), 32'd0);

    // Starvation: read wins on 5th cycle of contention
    rd_req_valid = 1'b1; rd_req_rs1 = 5'd3; rd_req_rs2 = 5'd4;
    wb_ex_valid = 1'b1; wb_ex_rd = 5'd10;
    for (int i = 0; i < 4; i++) begin
      wb_ex_data = 32'(100 + i);
      #1;
      check("stv_rd_blocked", 32'(rd_req_ready), 32'd0);
      check("stv_wr_ok", 32'(wb_ex_ready), 32'd1);
      tick();
    end
    #1;
    check("stv_rd_grant", 32'(rd_req_ready), 32'd1);
    check("stv_wr_stall", 32'(wb_ex_ready), 32'd0);
    check("stv_rf_rd_en", 32'(rf_rd_en), 32'd0);
    tick();
    rd_req_valid = 1'b0;
    #1;
    check("stv_rsp_rs1", rsp_rs1, 32'h33);
    check("stv_wr_resume", 32'(wb_ex_ready), 32'd1);
    tick();
    wb_ex_valid = 1'b0;

    // Reserve x5, read blocked until writeback
    rsv_valid = 1'b1; rsv_rd = 5'd5;
    #1;
    check("x5_rsv_ready", 32'(rsv_ready), 32'd1);
    tick();
    rsv_valid = 1'b0;
    rd_req_valid = 1'b1; rd_req_rs1 = 5'd5; rd_req_rs2 = 5'd0;
    #1;
    check("x5_rd_block1", 32'(rd_req_ready), 32'd0);
    tick();
    #1;
    check("x5_rd_block2", 32'(rd_req_ready), 32'd0);
    tick();
    wb_ex_valid = 1'b1; wb_ex_rd = 5'd5; wb_ex_data = 32'hDEAD;
    #1;
    check("x5_wb_ready", 32'(wb_ex_ready), 32'd1);
    check("x5_rd_block3", 32'(rd_req_ready), 32'd0);
    tick();
    wb_ex_valid = 1'b0;
    #1;
    check("x5_rd_elig", 32'(rd_req_ready), 32'd1);
    tick();
    rd_req_valid = 1'b0;
    #1;
    check("x5_rsp_valid", 32'(rsp_valid), 32'd1);
    check("x5_rsp_rs1", rsp_rs1, 32'hDEAD);
    check("x5_rsp_rs2", rsp_rs2, 32'd0);
    tick();

    // x0 reservation and write
    rsv_valid = 1'b1; rsv_rd = 5'd0;
    #1;
    check("x0_rsv_ready", 32'(rsv_ready), 32'd1);
    tick();
    rsv_valid = 1'b0;
    wb_ex_valid = 1'b1; wb_ex_rd = 5'd0; wb_ex_data = 32'h1234;
    #1;
    check("x0_wb_ready", 32'(wb_ex_ready), 32'd1);
    check("x0_rf_rd_en", 32'(rf_rd_en), 32'd0);
    tick();
    wb_ex_valid = 1'b0;
    rd_req_valid = 1'b1; rd_req_rs1 = 5'd0; rd_req_rs2 = 5'd0;
    #1;
    check("x0_rd_ready", 32'(rd_req_ready), 32'd1);
    tick();
    rd_req_valid = 1'b0;
    #1;
    check("x0_rsp_rs1", rsp_rs1, 32'd0);
    tick();

    // Double reservation of x7
    rsv_valid = 1'b1; rsv_rd = 5'd7;
    #1;
    check("x7_rsv1", 32'(rsv_ready), 32'd1);
    tick();
    #1;
    check("x7_rsv2_stall", 32'(rsv_ready), 32'd0);
    tick();
    wb_ld_valid = 1'b1; wb_ld_rd = 5'd7; wb_ld_data = 32'h77;
    #1;
    check("x7_wb_ready", 32'(wb_ld_ready), 32'd1);
    check("x7_rsv2_still", 32'(rsv_ready), 32'd0);
    tick();
    wb_ld_valid = 1'b0;
    #1;
    check("x7_rsv2_ok", 32'(rsv_ready), 32'd1);
    tick();
    rsv_valid = 1'b0;
    rd_req_valid = 1'b1; rd_req_rs1 = 5'd7; rd_req_rs2 = 5'd0;
    #1;
    check("x7_repend", 32'(rd_req_ready), 32'd0);
    tick();
    rd_req_valid = 1'b0;

    // Reset with a response in flight
    rsv_valid = 1'b1; rsv_rd = 5'd5;
    tick();
    rsv_valid = 1'b0;
    rd_req_valid = 1'b1; rd_req_rs1 = 5'd3; rd_req_rs2 = 5'd0;
    #1;
    check("rst_mid_grant", 32'(rd_req_ready), 32'd1);
    tick();
    rd_req_valid = 1'b0;
    #1;
    check("rst_mid_inflight", 32'(rsp_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_drop", 32'(rsp_valid), 32'd0);
    tick();
    rst = 1'b1;
    rd_req_valid = 1'b1; rd_req_rs1 = 5'd5; rd_req_rs2 = 5'd7;
    #1;
    check("rst_sb_clear", 32'(rd_req_ready), 32'd1);
    tick();
    rd_req_valid = 1'b0;
    #1;
    check("rst_rsp_rs1", rsp_rs1, 32'hDEAD);
    check("rst_rsp_rs2", rsp_rs2, 32'h77);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
